// File: rtl/paint_pkg.sv
// Shared types and screen geometry for the paint request arbiter.
package paint_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;

    typedef struct packed {
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic [15:0] radius;
    } paint_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/paint_req_fifo.sv
// Synchronous FIFO of circle requests; one instance per requester.
module paint_req_fifo
    import paint_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       push,
    input  paint_req_t push_data,
    input  logic       pop,
    output paint_req_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    paint_req_t  mem [FIFO_DEPTH];
    logic        push_en;
    logic        pop_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/paint_arbiter.sv
// Two-requester round-robin arbiter feeding a circle painter.
// Optional request clipping and drop counting enabled by `define PAINT_ARB_CLIP_EN.
module paint_arbiter
    import paint_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RADIUS = 64
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [1:0]       req_valid_in,
    output logic [1:0]       req_ready_out,
    input  logic [1:0][10:0] req_hcount_in,
    input  logic [1:0][9:0]  req_vcount_in,
    input  logic [1:0][15:0] req_radius_in,
    output logic             paint_valid_out,
    output logic [10:0]      paint_hcount_out,
    output logic [9:0]       paint_vcount_out,
    output logic [16:0]      paint_radius_out,
    input  logic             paint_ready_in,
    output logic             busy_out,
    output logic [15:0]      drop_count_out
);

    paint_req_t head [2];
    logic [1:0] fifo_empty;
    logic [1:0] fifo_full;
    logic [1:0] pop;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_grant;
    logic       grant_sel;
    logic       any_pending;
    logic       load_out;
    logic       reject;
    paint_req_t sel_req;
    paint_req_t out_req_p1;

    for (genvar i = 0; i < 2; i++) begin : g_req
        paint_req_t push_req;

        assign push_req = '{hcount: req_hcount_in[i],
                            vcount: req_vcount_in[i],
                            radius: req_radius_in[i]};

        paint_req_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .push      (req_valid_in[i]),
            .push_data (push_req),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (fifo_empty[i]),
            .full      (fifo_full[i])
        );
    end

    assign req_ready_out = ~fifo_full;
    assign any_pending   = (fifo_empty != 2'b11);

    // Tie goes to the requester not granted last; otherwise the only non-empty one.
    assign grant_sel = (fifo_empty == 2'b00) ? ~last_grant : fifo_empty[0];
    assign sel_req   = head[grant_sel];

`ifdef PAINT_ARB_CLIP_EN
    function automatic logic clip_reject(input paint_req_t r);
        logic [16:0] h;
        logic [16:0] v;
        logic [16:0] rad;
        h   = {6'd0, r.hcount};
        v   = {7'd0, r.vcount};
        rad = {1'b0, r.radius};
        return (rad > 17'(MAX_RADIUS)) || (h < rad) || (v < rad) ||
               (h + rad > 17'(H_ACTIVE - 1)) || (v + rad > 17'(V_ACTIVE - 1));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] drop_cnt;

    assign reject = clip_reject(sel_req);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_cnt <= '0;
        end else if ((pop != 2'b00) && reject) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign drop_count_out = drop_cnt;
`else
    logic [31:0] unused_max_radius;

    assign unused_max_radius = 32'(MAX_RADIUS);
    assign reject            = 1'b0;
    assign drop_count_out    = '0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 2'b00;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (paint_ready_in && any_pending) begin
                    pop[grant_sel] = 1'b1;
                    if (!reject) begin
                        load_out  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE:       state_nxt = WAIT_ACCEPT;
            WAIT_ACCEPT: if (!paint_ready_in) state_nxt = WAIT_DONE;
            WAIT_DONE:   if (paint_ready_in)  state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Grant stage: popped head captured into the output register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            out_req_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (pop != 2'b00) last_grant <= grant_sel;
            if (load_out)     out_req_p1 <= sel_req;
        end
    end

    assign paint_valid_out  = (state == ISSUE);
    assign busy_out         = (state != IDLE);
    assign paint_hcount_out = out_req_p1.hcount;
    assign paint_vcount_out = out_req_p1.vcount;
    assign paint_radius_out = {1'b0, out_req_p1.radius};

endmodule

// File: tb/tb_paint_arbiter.sv
// Randomised scoreboard bench for paint_arbiter with a queue-based reference model.
module tb_paint_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXR  = 64;
`ifdef PAINT_ARB_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [1:0]       req_valid_in;
    logic [1:0]       req_ready_out;
    logic [1:0][10:0] req_hcount_in;
    logic [1:0][9:0]  req_vcount_in;
    logic [1:0][15:0] req_radius_in;
    logic             paint_valid_out;
    logic [10:0]      paint_hcount_out;
    logic [9:0]       paint_vcount_out;
    logic [16:0]      paint_radius_out;
    logic             paint_ready_in;
    logic             busy_out;
    logic [15:0]      drop_count_out;

    paint_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_RADIUS (MAXR)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_hcount_in    (req_hcount_in),
        .req_vcount_in    (req_vcount_in),
        .req_radius_in    (req_radius_in),
        .paint_valid_out  (paint_valid_out),
        .paint_hcount_out (paint_hcount_out),
        .paint_vcount_out (paint_vcount_out),
        .paint_radius_out (paint_radius_out),
        .paint_ready_in   (paint_ready_in),
        .busy_out         (busy_out),
        .drop_count_out   (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {int h; int v; int r;} mreq_t;
    typedef struct {int h; int v; int r; int cyc;} exp_t;

    mreq_t mq0[$];
    mreq_t mq1[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    m_phase;     // 0 idle, 1 strobe, 2 waiting for painter to drop ready, 3 waiting for it to return
    int    m_last;
    int    m_drops;
    int    painter_cnt;
    int    next_busy_len;
    bit    hold_low;
    int    nchecks = 0;
    int    nerrors = 0;

    function automatic mreq_t mk(input int h, input int v, input int r);
        mreq_t q;
        q.h = h; q.v = v; q.r = r;
        return q;
    endfunction

    function automatic bit clip_bad(input mreq_t q);
        return CLIP_EN && (q.r > MAXR || q.h < q.r || q.v < q.r ||
                           q.h + q.r > 1279 || q.v + q.r > 719);
    endfunction

    task automatic check(input string name, input int act, input int req);
        nchecks++;
        if (act != req) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_state();
        check("req_ready0", int'(req_ready_out[0]), int'(mq0.size() < DEPTH));
        check("req_ready1", int'(req_ready_out[1]), int'(mq1.size() < DEPTH));
        check("busy", int'(busy_out), int'(m_phase != 0));
        check("drop_count", int'(drop_count_out), m_drops);
    endtask

    task automatic model_step(input mreq_t d0, input mreq_t d1);
        bit    a0;
        bit    a1;
        int    sel;
        mreq_t it;
        exp_t  e;
        a0 = req_valid_in[0] && (mq0.size() < DEPTH);
        a1 = req_valid_in[1] && (mq1.size() < DEPTH);
        case (m_phase)
            0: if (paint_ready_in && (mq0.size() > 0 || mq1.size() > 0)) begin
                if (mq0.size() > 0 && mq1.size() > 0) sel = 1 - m_last;
                else sel = (mq0.size() > 0) ? 0 : 1;
                it = (sel == 1) ? mq1.pop_front() : mq0.pop_front();
                m_last = sel;
                if (clip_bad(it)) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    e.h = it.h; e.v = it.v; e.r = it.r; e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    m_phase = 1;
                    painter_cnt = (next_busy_len > 0) ? next_busy_len : int'($urandom_range(2, 8));
                    next_busy_len = 0;
                end
            end
            1: m_phase = 2;
            2: if (!paint_ready_in) m_phase = 3;
            default: if (paint_ready_in) m_phase = 0;
        endcase
        if (a0) mq0.push_back(d0);
        if (a1) mq1.push_back(d1);
    endtask

    task automatic cycle(input logic [1:0] v, input mreq_t d0, input mreq_t d1);
        @(negedge clk_in);
        check_state();
        if (hold_low) paint_ready_in = 1'b0;
        else if (painter_cnt > 0) begin
            paint_ready_in = 1'b0;
            painter_cnt--;
        end else paint_ready_in = 1'b1;
        req_valid_in     = v;
        req_hcount_in[0] = 11'(d0.h);
        req_vcount_in[0] = 10'(d0.v);
        req_radius_in[0] = 16'(d0.r);
        req_hcount_in[1] = 11'(d1.h);
        req_vcount_in[1] = 10'(d1.v);
        req_radius_in[1] = 16'(d1.r);
        model_step(d0, d1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, mk(0, 0, 0), mk(0, 0, 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || m_phase != 0 || exp_q.size() > 0) && n < 1000) begin
            idle(1);
            n++;
        end
        check("drain_in_time", int'(n < 1000), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in       = 1'b0;
        req_valid_in   = 2'b00;
        paint_ready_in = 1'b1;
        #1;
        check("rst_paint_valid", int'(paint_valid_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_drop", int'(drop_count_out), 0);
        check("rst_hcount", int'(paint_hcount_out), 0);
        check("rst_vcount", int'(paint_vcount_out), 0);
        check("rst_radius", int'(paint_radius_out), 0);
        check("rst_ready", int'(req_ready_out), 3);
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        m_phase = 0; m_last = 1; m_drops = 0;
        painter_cnt = 0; next_busy_len = 0; hold_low = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    function automatic mreq_t rnd_req();
        int r;
        r = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 90));
        return mk(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), r);
    endfunction

    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && paint_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_cycle", cyc, mon_e.cyc);
                check("issue_hcount", int'(paint_hcount_out), mon_e.h);
                check("issue_vcount", int'(paint_vcount_out), mon_e.v);
                check("issue_radius", int'(paint_radius_out), mon_e.r);
            end
        end
    end

    initial begin
        logic [1:0] v;
        rst_n_in       = 1'b0;
        req_valid_in   = 2'b00;
        req_hcount_in  = '0;
        req_vcount_in  = '0;
        req_radius_in  = '0;
        paint_ready_in = 1'b1;
        hold_low       = 1'b0;
        painter_cnt    = 0;
        next_busy_len  = 0;

        // single request
        do_reset();
        cycle(2'b01, mk(640, 360, 10), mk(0, 0, 0));
        drain();

        // fairness with both queues preloaded
        do_reset();
        hold_low = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(2'b11, mk(100 + i, 100, 10 + i), mk(200 + i, 200, 20 + i));
        idle(2);
        hold_low = 1'b0;
        drain();

        // full queue: fifth push is lost
        hold_low = 1'b1;
        for (int i = 0; i < 5; i++) cycle(2'b01, mk(300 + 10 * i, 300, 5 + i), mk(0, 0, 0));
        idle(2);
        hold_low = 1'b0;
        drain();

        // painter holds ready low for a long stroke
        next_busy_len = 50;
        cycle(2'b10, mk(0, 0, 0), mk(500, 300, 20));
        cycle(2'b10, mk(0, 0, 0), mk(510, 310, 21));
        drain();

        // clipping candidates and an oversized radius
        cycle(2'b01, mk(5, 360, 10), mk(0, 0, 0));
        cycle(2'b01, mk(640, 360, 10), mk(0, 0, 0));
        cycle(2'b10, mk(0, 0, 0), mk(1000, 500, 65535));
        drain();

        // reset while waiting for the painter, with requests still queued
        next_busy_len = 40;
        cycle(2'b01, mk(400, 400, 8), mk(0, 0, 0));
        cycle(2'b10, mk(0, 0, 0), mk(401, 401, 9));
        cycle(2'b10, mk(0, 0, 0), mk(402, 402, 9));
        for (int i = 0; i < 20 && m_phase != 3; i++) idle(1);
        do_reset();
        idle(20);
        cycle(2'b01, mk(700, 350, 30), mk(0, 0, 0));
        drain();

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            cycle(v, rnd_req(), rnd_req());
        end
        drain();
        check("leftover_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/paint_arbiter.md
PAINT_ARBITER -- requirements
Module: paint_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-requester queue depth (power of two, >=2).
REQ-002 SHALL have parameter MAX_RADIUS, default 64, largest radius accepted when clipping is enabled.
REQ-003 SHALL have port clk_in, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_in, input, 2, per-requester push strobe.
REQ-006 SHALL have port req_ready_out, output, 2, per-requester queue not full.
REQ-007 SHALL have ports req_hcount_in [2][11], req_vcount_in [2][10] and req_radius_in [2][16], all inputs, giving circle centre and radius per requester.
REQ-008 SHALL have port paint_valid_out, output, 1, one-cycle start strobe to the painter data_valid_in.
REQ-009 SHALL have ports paint_hcount_out (11), paint_vcount_out (10) and paint_radius_out (17), all outputs, carrying the issued circle.
REQ-010 SHALL have port paint_ready_in, input, 1, painter ready_out.
REQ-011 SHALL have port busy_out, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port drop_count_out, output, 16, count of discarded requests.

Function
REQ-013 SHALL push a request into queue i when req_valid_in[i] && req_ready_out[i]; pushes on a full queue are ignored, with no bypass.
REQ-014 SHALL drive req_ready_out[i] from not-full only; a pop in the same cycle does not raise it until the next cycle.
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT_ACCEPT -> WAIT_DONE -> IDLE.
REQ-016 IDLE: when paint_ready_in=1 and any queue is non-empty, SHALL grant round-robin (the requester not last granted wins a tie), pop its head into the output registers and go to ISSUE.
REQ-017 ISSUE: SHALL assert paint_valid_out for exactly one cycle with registered coordinates, then go to WAIT_ACCEPT.
REQ-018 WAIT_ACCEPT: SHALL remain until paint_ready_in=0, then go to WAIT_DONE.
REQ-019 WAIT_DONE: SHALL remain until paint_ready_in=1, then go to IDLE; the next issue can never occur sooner than the cycle after IDLE is re-entered.
REQ-020 Latency: a push into empty queues at cycle N with the painter ready SHALL produce paint_valid_out at cycle N+2.
REQ-021 SHALL zero-extend paint_radius_out from the 16-bit request radius.
REQ-022 SHALL hold paint_*_out stable from ISSUE until the next grant.
REQ-023 Simultaneous push to a queue and pop from it SHALL both take effect, leaving occupancy unchanged.
REQ-024 A single active requester SHALL be granted back-to-back without waiting on the other.

Reset
REQ-025 On rst_n_in=0 SHALL immediately empty both queues and clear state to IDLE, last-grant to requester 1, paint_valid_out, paint_*_out, busy_out and drop_count_out to 0.
REQ-026 Reset mid-stroke SHALL abandon the stroke; the painter is reset together with this block.
REQ-027 req_ready_out SHALL read 2'b11 the first cycle after reset is released.

Configuration
REQ-028 With PAINT_ARB_CLIP_EN defined, a popped request SHALL be discarded in IDLE without an issue if any of the following holds:
- radius>MAX_RADIUS
- hcount<radius
- vcount<radius
- hcount+radius>H_ACTIVE-1
- vcount+radius>V_ACTIVE-1
REQ-029 On such a discard, SHALL increment drop_count_out (saturating at 16'hFFFF), advance last-grant and stay in IDLE.
REQ-030 Without PAINT_ARB_CLIP_EN, SHALL issue every request unchecked and tie drop_count_out to 0.

Structure
REQ-031 Package paint_pkg SHALL hold paint_req_t (hcount 11, vcount 10, radius 16), the arb_state_t enum, and H_ACTIVE=1280 and V_ACTIVE=720.
REQ-032 SHALL instantiate sub-module paint_req_fifo (synchronous FIFO of paint_req_t, depth FIFO_DEPTH) once per requester.

Verification
REQ-033 Single request: push req0 (640,360,r=10) with painter ready -> paint_valid_out 1 cycle at N+2 with 640/360/10; busy_out until ready returns.
REQ-034 Fairness: both queues loaded with 3 requests each -> issue order 0,1,0,1,0,1.
REQ-035 Full queue: 5 pushes to req0 while painter busy -> req_ready_out[0]=0 after the 4th push; the 5th is lost; exactly 4 issued.
REQ-036 Handshake: painter holds ready low 50 cycles -> no second paint_valid_out until ready is high again and IDLE is re-entered.
REQ-037 Clip (macro on): request (5,360,r=10) -> no issue, drop_count_out=1; following valid request issued next; macro off -> same request issued.
REQ-038 Reset mid-WAIT_DONE with 2 requests queued -> outputs 0, queues empty, no issue after release until a new push.
